// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: serialises a parallel payload LSB-first and
// steers the downstream registered 4:1 line mux through start/data/parity/stop.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  par_en_reg, par_en_next;

    logic                  accept;
    logic                  last_bit;
    logic                  par_calc;
    logic [DATA_WIDTH-1:0] par_chain;

    // Running XOR across the payload; the final tap is the even parity.
    assign par_chain[0] = p_data[0];
    generate
        for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_par
            assign par_chain[gi] = par_chain[gi-1] ^ p_data[gi];
        end
    endgenerate

    assign par_calc = par_chain[DATA_WIDTH-1] ^ par_typ;

    // STOP is non-busy so a waiting request starts the next frame with no gap.
    assign accept   = data_valid && ((state_reg == ST_IDLE) || (state_reg == ST_STOP));
    assign last_bit = (cnt_reg == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            par_bit_reg <= 1'b0;
            par_en_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            par_bit_reg <= par_bit_next;
            par_en_reg  <= par_en_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        par_bit_next = par_bit_reg;
        par_en_next  = par_en_reg;

        case (state_reg)
            ST_IDLE, ST_STOP: begin
                if (accept) begin
                    state_next   = ST_START;
                    shift_next   = p_data;
                    par_bit_next = par_calc;
                    par_en_next  = par_en;
                    cnt_next     = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                state_next = ST_DATA;
            end
            ST_DATA: begin
                shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
                if (last_bit) begin
                    cnt_next   = '0;
                    state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                state_next = ST_STOP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mux_sel = SEL_STOP;
        busy    = 1'b0;
        case (state_reg)
            ST_START: begin
                mux_sel = SEL_START;
                busy    = 1'b1;
            end
            ST_DATA: begin
                mux_sel = SEL_DATA;
                busy    = 1'b1;
            end
            ST_PARITY: begin
                mux_sel = SEL_PARITY;
                busy    = 1'b1;
            end
            default: begin
                mux_sel = SEL_STOP;
                busy    = 1'b0;
            end
        endcase
    end

    assign ser_data = shift_reg[0];
    assign par_bit  = par_bit_reg;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side frame controller for the UART TX path. It accepts a parallel byte, serialises it LSB-first and computes its parity. It sequences start, data, optional parity and stop bits by driving the select, serial-data and parity-bit inputs of the downstream registered 4:1 output mux. One frame bit is produced per clk cycle; clk is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>= 2)

Ports:
clk  input  1  baud-rate clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
p_data  input  DATA_WIDTH  parallel payload; sampled only on acceptance
data_valid  input  1  request to send p_data
par_en  input  1  1 = insert parity bit; sampled on acceptance
par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance
mux_sel  output  2  downstream mux select: 00 start, 01 stop/idle, 10 data, 11 parity
ser_data  output  1  current data bit (shift register LSB)
par_bit  output  1  parity bit of the latched frame
busy  output  1  frame in progress; new requests are ignored

Behaviour:
- Reset (async on rst high): state IDLE, shift register 0, bit counter 0, par_bit 0, busy 0, mux_sel 01. The line stays high, with no spurious start bit.
- Reset asserted mid-frame aborts the frame immediately. After release, the block sits in IDLE, and no partial frame resumes.
- State register: IDLE, START, DATA, PARITY, STOP. All outputs are Moore outputs, decoded from registers only.
- mux_sel decode: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
- Acceptance: state is IDLE or STOP and data_valid = 1 at a rising edge. On acceptance:
  - shift_reg <= p_data
  - par_bit <= (^p_data) XOR par_typ
  - par_en is latched
  - bit counter <= 0
  - next state START
- data_valid is ignored in START, DATA and PARITY. Requests there are dropped, not queued.
- Transitions:
  - IDLE -> START on acceptance; otherwise stay in IDLE.
  - START -> DATA after 1 cycle.
  - DATA holds DATA_WIDTH cycles. Each cycle in DATA, shift_reg shifts right by 1 and the counter increments. On the counter reaching DATA_WIDTH-1, go to PARITY if latched par_en = 1, else STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START on acceptance (back-to-back frames with no idle gap); otherwise -> IDLE.
- ser_data = shift_reg[0], valid as data bit i during the i-th DATA cycle.
- par_bit is stable from acceptance until the next acceptance.
- busy = 1 in START, DATA and PARITY. busy = 0 in IDLE and STOP, so a request during STOP is accepted.
- Latency: if acceptance occurs at edge k:
  - mux_sel = 00 during cycle k..k+1
  - data bits cover cycles k+1..k+DATA_WIDTH
  - parity (if enabled) at k+DATA_WIDTH+1
  - then stop
- Frame length is DATA_WIDTH+2 cycles, or +3 with parity. The downstream mux adds one further register stage on the line.
- Parity changes (par_en, par_typ) and p_data changes while busy have no effect on the current frame.

Test Plan:
- Reset: assert rst mid-DATA of a frame -> immediately mux_sel = 01, busy = 0, par_bit = 0; after release the block stays IDLE until data_valid.
- Even parity: p_data = 8'hA5, par_en = 1, par_typ = 0 ->
  - mux_sel sequence 00, 10×8, 11, 01
  - ser_data sequence during DATA: 1,0,1,0,0,1,0,1
  - par_bit = 0
- Odd parity: p_data = 8'hA5, par_en = 1, par_typ = 1 -> same sequence, par_bit = 1.
- No parity: p_data = 8'h01, par_en = 0 ->
  - 10-cycle frame 00, 10×8, 01
  - ser_data = 1 in the first DATA cycle only
  - no 11 select ever seen
- Back-to-back: data_valid held high with 8'h3C then 8'hC3 -> the second START immediately follows the first STOP; both payloads are serialised correctly.
- Ignored request: pulse data_valid with 8'hFF during DATA of a 8'h00 frame -> the frame still sends all-zero data, and no extra frame follows.
